// File: rtl/tone_gen.sv
// tone_gen: square-wave tone generator in the style of an SN76489 tone channel.
// The output alternates between a programmed magnitude and zero. Each level is
// held for PRESCALE*N clock cycles, where N = 0 stands for 2^CNT_W. Period and
// magnitude are double-buffered: a load only fills the shadow registers, and
// the shadow values take effect at the next level boundary or at channel start.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   enable      1 = generate tone; 0 = output forced to 0, channel idle
//   load        one-cycle strobe capturing period_in/mag_in into the shadows
//   period_in   half-period N in ticks (0 means 2^CNT_W)
//   mag_in      magnitude of the high level
//   out_signal  magnitude during the high phase, 0 during the low phase
//   phase       current phase (1 = high)
//   phase_edge  one-cycle pulse on every phase change. This is the "edge"
//               output; edge is a reserved word, so the port cannot be named so.
//   pending     shadow values loaded but not yet applied
module tone_gen #(
  parameter int CNT_W    = 10,
  parameter int MAG_W    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] period_in,
  input  logic [MAG_W-1:0] mag_in,
  output logic [MAG_W-1:0] out_signal,
  output logic             phase,
  output logic             phase_edge,
  output logic             pending
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] shadow_per;
  logic [CNT_W-1:0] act_per;
  logic [MAG_W-1:0] shadow_mag;
  logic [MAG_W-1:0] act_mag;
  logic [PS_W-1:0]  ps;
  logic [CNT_W-1:0] cnt;

  // Tick count reloads use N-1 in CNT_W bits. N = 0 wraps to 2^CNT_W-1,
  // which is exactly eff(0)-1, so no special case is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_signal <= '0;
      phase      <= 1'b0;
      phase_edge <= 1'b0;
      pending    <= 1'b0;
      ps         <= '0;
      cnt        <= '0;
      shadow_per <= CNT_W'(1);
      shadow_mag <= '0;
      act_per    <= CNT_W'(1);
      act_mag    <= '0;
    end else begin
      phase_edge <= 1'b0;

      if (load) begin
        shadow_per <= period_in;
        shadow_mag <= mag_in;
        pending    <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            // A load in the start cycle is applied directly and is not
            // left pending.
            if (load) begin
              act_per    <= period_in;
              act_mag    <= mag_in;
              cnt        <= period_in - CNT_W'(1);
              out_signal <= mag_in;
            end else begin
              act_per    <= shadow_per;
              act_mag    <= shadow_mag;
              cnt        <= shadow_per - CNT_W'(1);
              out_signal <= shadow_mag;
            end
            pending    <= 1'b0;
            state      <= ST_RUN;
            phase      <= 1'b1;
            phase_edge <= 1'b1;
            ps         <= PS_MAX;
          end
        end

        ST_RUN: begin
          if (!enable) begin
            state      <= ST_IDLE;
            out_signal <= '0;
            phase      <= 1'b0;
            ps         <= '0;
            cnt        <= '0;
            phase_edge <= (out_signal != '0);
          end else if (ps != '0) begin
            ps <= ps - PS_W'(1);
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            ps  <= PS_MAX;
          end else begin
            phase      <= ~phase;
            phase_edge <= 1'b1;
            ps         <= PS_MAX;
            if (pending) begin
              act_per    <= shadow_per;
              act_mag    <= shadow_mag;
              cnt        <= shadow_per - CNT_W'(1);
              out_signal <= phase ? '0 : shadow_mag;
              // A load in this same cycle refills the shadows and must stay
              // pending for the following boundary.
              if (!load) pending <= 1'b0;
            end else begin
              cnt        <= act_per - CNT_W'(1);
              out_signal <= phase ? '0 : act_mag;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: one instance with PRESCALE=1 and one with
// PRESCALE=16, sharing clock and reset. Level lengths are measured in cycles
// between phase_edge pulses and compared with hand-computed values.
module tb_tone_gen;

  logic       clk = 1'b0;
  logic       reset;

  logic       en1, ld1;
  logic [9:0] per1;
  logic [7:0] mag1;
  logic [7:0] out1;
  logic       ph1, ed1, pd1;

  logic       en16, ld16;
  logic [9:0] per16;
  logic [7:0] mag16;
  logic [7:0] out16;
  logic       ph16, ed16, pd16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_gen #(.CNT_W(10), .MAG_W(8), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(en1), .load(ld1),
    .period_in(per1), .mag_in(mag1), .out_signal(out1),
    .phase(ph1), .phase_edge(ed1), .pending(pd1)
  );

  tone_gen #(.CNT_W(10), .MAG_W(8), .PRESCALE(16)) u_dut16 (
    .clk(clk), .reset(reset), .enable(en16), .load(ld16),
    .period_in(per16), .mag_in(mag16), .out_signal(out16),
    .phase(ph16), .phase_edge(ed16), .pending(pd16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until the selected instance pulses phase_edge; 0 on timeout.
  task automatic wait_edge(input bit sel16, input int limit, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      tick();
      n++;
      seen = sel16 ? ed16 : ed1;
    end
    if (!seen) n = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic       eph;
    reset = 1'b1;
    en1 = 0; ld1 = 0; per1 = '0; mag1 = '0;
    en16 = 0; ld16 = 0; per16 = '0; mag16 = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1: reset state, load N=5 mag=0x80, start
    check("rst_out", out1, 0);
    check("rst_phase", ph1, 0);
    check("rst_edge", ed1, 0);
    check("rst_pending", pd1, 0);
    per1 = 10'd5; mag1 = 8'h80; ld1 = 1;
    tick();
    check("load_pending", pd1, 1);
    check("load_out_idle", out1, 0);
    ld1 = 0; en1 = 1;
    tick();
    check("start_out", out1, 8'h80);
    check("start_phase", ph1, 1);
    check("start_edge", ed1, 1);
    check("start_pending", pd1, 0);
    wait_edge(1'b0, 100, n);
    check("n5_high_len", n, 5);
    check("n5_low_out", out1, 0);
    check("n5_low_phase", ph1, 0);
    wait_edge(1'b0, 100, n);
    check("n5_low_len", n, 5);
    check("n5_high_out", out1, 8'h80);

    // 2: load N=3 mid-high; current level still 5 long
    tick();
    check("nonbound_edge", ed1, 0);
    per1 = 10'd3; ld1 = 1;
    tick();
    check("mid_pending", pd1, 1);
    ld1 = 0;
    wait_edge(1'b0, 100, n);
    check("reload_rest_len", n, 3);
    check("reload_pending_clr", pd1, 0);
    check("reload_low_out", out1, 0);
    wait_edge(1'b0, 100, n);
    check("n3_low_len", n, 3);
    check("n3_high_out", out1, 8'h80);

    // 5: drop enable mid-high, then re-enable
    tick();
    en1 = 0;
    tick();
    check("dis_out", out1, 0);
    check("dis_phase", ph1, 0);
    check("dis_edge", ed1, 1);
    tick();
    check("dis_edge_once", ed1, 0);
    en1 = 1;
    tick();
    check("reen_out", out1, 8'h80);
    check("reen_edge", ed1, 1);
    check("reen_phase", ph1, 1);
    wait_edge(1'b0, 100, n);
    check("reen_high_len", n, 3);
    check("reen_low_out", out1, 0);

    // 6: reset mid-low with enable held high -> defaults N=1, mag=0
    tick();
    reset = 1;
    tick();
    check("mrst_out", out1, 0);
    check("mrst_phase", ph1, 0);
    check("mrst_edge", ed1, 0);
    check("mrst_pending", pd1, 0);
    reset = 0;
    tick();
    check("dflt_start_edge", ed1, 1);
    check("dflt_start_phase", ph1, 1);
    check("dflt_start_out", out1, 0);
    tick();
    check("dflt_edge2", ed1, 1);
    check("dflt_phase2", ph1, 0);
    tick();
    check("dflt_edge3", ed1, 1);
    check("dflt_phase3", ph1, 1);

    // 4a: N=1 with nonzero magnitude; load lands on a boundary, applies at the next
    per1 = 10'd1; mag1 = 8'h55; ld1 = 1;
    tick();
    check("n1_pending", pd1, 1);
    check("n1_old_out", out1, 0);
    ld1 = 0;
    tick();
    check("n1_apply_out", out1, 8'h55);
    check("n1_apply_pending", pd1, 0);
    eph = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      eph = ~eph;
      check("n1_toggle_edge", ed1, 1);
      check("n1_toggle_out", out1, eph ? 8'h55 : 8'h00);
    end

    // 4b: N=0 means 1024 ticks per level
    per1 = 10'd0; mag1 = 8'h80; ld1 = 1;
    tick();
    ld1 = 0;
    tick();
    check("n0_apply_out", out1, 8'h80);
    wait_edge(1'b0, 1100, n);
    check("n0_high_len", n, 1024);
    check("n0_low_out", out1, 0);
    wait_edge(1'b0, 1100, n);
    check("n0_low_len", n, 1024);
    check("n0_high_out", out1, 8'h80);

    // 3: PRESCALE=16, N=2; two loads before a boundary, last one wins
    en1 = 0;
    reset = 1;
    tick();
    reset = 0;
    per16 = 10'd2; mag16 = 8'hFF; ld16 = 1;
    tick();
    check("p16_pending", pd16, 1);
    ld16 = 0; en16 = 1;
    tick();
    check("p16_start_out", out16, 8'hFF);
    check("p16_start_edge", ed16, 1);
    wait_edge(1'b1, 100, n);
    check("p16_high_len", n, 32);
    check("p16_low_out", out16, 0);
    tick();
    per16 = 10'd4; mag16 = 8'h11; ld16 = 1;
    tick();
    per16 = 10'd1; mag16 = 8'h22;
    tick();
    ld16 = 0;
    check("p16_dbl_pending", pd16, 1);
    wait_edge(1'b1, 100, n);
    check("p16_low_len", n, 29);
    check("p16_last_mag", out16, 8'h22);
    check("p16_apply_pending", pd16, 0);
    wait_edge(1'b1, 100, n);
    check("p16_last_len", n, 16);
    check("p16_last_low_out", out16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Square-wave tone generator modelled on an SN76489 tone channel; the stimulus-side counterpart of the half-period frequency detector in the verification bench.
- Produces an 8-bit level that alternates between a programmed magnitude and zero.
- Each level is held for a programmed half-period of PRESCALE*N clock cycles.
- Period and magnitude updates are double-buffered, so they apply only at level boundaries and never cause glitches.

Parameters:
- CNT_W, 10, width of the half-period count N
- MAG_W, 8, width of magnitude and output level
- PRESCALE, 1, clk cycles per count tick (SN76489 style uses 16); must be >= 1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = generate tone; 0 = output forced to 0, channel idle
- load  in  1  one-cycle strobe that captures period_in and mag_in into the shadow registers
- period_in  in  CNT_W  half-period N in ticks; 0 means 2^CNT_W
- mag_in  in  MAG_W  high-level magnitude
- out_signal  out  MAG_W  generated level: magnitude during the high phase, 0 during the low phase
- phase  out  1  current phase (1 = high)
- edge  out  1  one-cycle pulse on every cycle where out_signal changes phase
- pending  out  1  shadow values loaded but not yet applied

Behaviour:
- Registers:
  - shadow_per, shadow_mag: written by load.
  - act_per, act_mag: in effect now.
  - ps: prescaler, 0..PRESCALE-1.
  - cnt: tick down-counter.
  - active flag.
- Reset (synchronous, overrides all):
  - out_signal=0, phase=0, edge=0, pending=0, active=0.
  - ps=0, cnt=0.
  - shadow_per=1, shadow_mag=0, act_per=1, act_mag=0.
- load=1:
  - shadow_per<=period_in, shadow_mag<=mag_in, pending<=1 on the next edge.
  - A later load before the values are applied overwrites the shadows; last one wins.
- Start (active=0 and enable=1 sampled):
  - On the next edge: act_per/act_mag <= shadows, or <= period_in/mag_in when load is also high that cycle.
  - Same edge: pending<=0, active<=1, phase<=1, out_signal<=mag, edge<=1.
  - Same edge: cnt<=eff(N)-1, ps<=PRESCALE-1, where eff(0)=2^CNT_W.
- Running (active=1, enable=1), each clk:
  - If ps!=0: ps<=ps-1, no change elsewhere.
  - Else if cnt!=0: cnt<=cnt-1, ps<=PRESCALE-1.
  - Else (boundary): phase<=~phase, edge<=1.
    - If pending: act_* <= shadow_*, pending<=0 (load in the same cycle applies at the following boundary).
    - cnt<=eff(new act_per)-1, ps<=PRESCALE-1.
    - out_signal <= new phase ? new act_mag : 0.
  - edge=0 on every non-boundary cycle.
- Resulting timing:
  - Each level is held exactly PRESCALE*eff(N) cycles.
  - Full period is 2*PRESCALE*eff(N) cycles.
  - First high phase starts 1 cycle after enable is sampled.
- enable=0 while active:
  - Next edge: active<=0, out_signal<=0, phase<=0, ps<=0, cnt<=0.
  - edge<=1 only if out_signal was nonzero.
  - Shadows and pending are kept.
  - Re-enable restarts with a fresh high phase.
- Magnitude 0: phases still toggle and edge still pulses; out_signal stays 0.
- N=1 with PRESCALE=1: output toggles every cycle.
- Max N=0 gives 1024 ticks per level at CNT_W=10. Counters must not overflow: cnt needs CNT_W bits holding 2^CNT_W-1.
- Reset asserted mid-phase: full reset on that edge; no residual edge pulse.
- Behaviour is purely synchronous; no combinational paths from inputs to outputs.

Test Plan:
1. Reset, load N=5 and mag=0x80 with PRESCALE=1, then enable=1 → out_signal goes 0x80 one cycle later and alternates 0x80/0x00 every 5 cycles; edge pulses 5 cycles apart; pending clears at start.
2. Running at N=5, load N=3 mid-high-phase → current high lasts 5 cycles; all subsequent levels last 3 cycles; pending is high from load until that boundary.
3. PRESCALE=16, N=2, mag=0xFF → each level lasts 32 cycles; two consecutive loads before the boundary → only the second value is applied.
4. N=0 (CNT_W=10) → each level lasts 1024 cycles; N=1 → out_signal toggles every cycle with edge continuously 1.
5. Drop enable mid-high-phase → next cycle out_signal=0, phase=0, edge=1; re-enable → fresh 0x80 high phase of full length.
6. Assert reset for 1 cycle mid-low-phase → all outputs 0, pending=0; enable still high → restart using act/shadow defaults (N=1, mag=0), giving edge every cycle and out_signal=0.
